// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the async FIFO read-side blocks.
// Pointer and occupancy widths are derived from clog2.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int STATS_W         = 32;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Output buffer for the FIFO read stream: storage array, head/tail pointers and occupancy.
// The pointers wrap modulo BUF_DEPTH, so the depth need not be a power of two.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter  int BUF_DEPTH  = 3,
    localparam int PTR_W      = (clog2(BUF_DEPTH) < 1) ? 1 : clog2(BUF_DEPTH),
    localparam int OCC_W      = clog2(BUF_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [OCC_W-1:0]      o_occ
);

    logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [OCC_W-1:0]      r_occ;
    logic [PTR_W-1:0]      w_head_nxt;
    logic [PTR_W-1:0]      w_tail_nxt;

    localparam logic [PTR_W-1:0] LAST = PTR_W'(BUF_DEPTH - 1);

    assign w_head_nxt = (r_head == LAST) ? '0 : r_head + 1'b1;
    assign w_tail_nxt = (r_tail == LAST) ? '0 : r_tail + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (i_wr) begin
                r_buf[r_tail] <= i_wr_data;
                r_tail        <= w_tail_nxt;
            end
            if (i_pop) begin
                r_head <= w_head_nxt;
            end
            r_occ <= r_occ + OCC_W'(i_wr) - OCC_W'(i_pop);
        end
    end

    assign o_data  = r_buf[r_head];
    assign o_valid = (r_occ != '0);
    assign o_occ   = r_occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a valid/ready stream using credit-based pops.
// Optional word counter is enabled by defining FIFO_RD_STATS_EN.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [STATS_W-1:0]    word_count
`endif
);

    localparam int OCC_W = clog2(BUF_DEPTH + 1);

    logic             r_inflight;
    logic [OCC_W-1:0] w_occ;
    logic             w_credit;
    logic             w_issue;
    logic             w_pop;

    // Credit counts words already held plus the one still on its way from the FIFO
    assign w_credit   = (int'(w_occ) + int'(r_inflight)) < BUF_DEPTH;
    assign fifo_rd_en = !rst && w_credit;
    assign w_issue    = fifo_rd_en && !fifo_empty;
    assign w_pop      = m_valid && m_ready;

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
        end
    end

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .i_clk     (rd_clk),
        .i_rst     (rst),
        .i_wr      (r_inflight),
        .i_wr_data (fifo_read_data),
        .i_pop     (w_pop),
        .o_data    (m_data),
        .o_valid   (m_valid),
        .o_occ     (w_occ)
    );

`ifdef FIFO_RD_STATS_EN
    logic [STATS_W-1:0] r_word_count;

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_word_count <= '0;
        end else if (w_pop) begin
            r_word_count <= r_word_count + 1'b1;
        end
    end

    assign word_count = r_word_count;
`endif

endmodule
